conv3x3_window_mac: RTL and testbench

- Consumes the pixel stream read from image memory at addresses produced by the 3x3 window address generator.
- Nine pixels per window, column-major order (top, middle, bottom of column 0, then column 1, then column 2).
- Each pixel is multiplied by a programmable 3x3 kernel coefficient and accumulated in a semi-systolic MAC pipeline. Each window result is scaled and clamped to an 8-bit pixel.
- Emits the result with a sequential output address for the result-image memory.

---
 rtl/conv3x3_window_mac_pkg.sv | 19 +
 rtl/conv3x3_window_mac_mac_stage.sv | 58 +++++
 rtl/conv3x3_window_mac.sv | 122 ++++++++++++
 tb/tb_conv3x3_window_mac.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_window_mac_pkg.sv
// Shared constants for the 3x3 convolution datapath and its upstream window
// address generator: pixel/coefficient/accumulator widths, frame geometry and
// tap ordering (t = 3*column + row, column-major, so tap 4 is the centre).
package conv3x3_window_mac_pkg;

    localparam int PIX_W      = 8;     // unsigned pixel width
    localparam int COEF_W     = 8;     // signed coefficient width
    localparam int ACC_W      = 21;    // 9-bit signed pixel x 8-bit coef = 17 bits, +4 guard
    localparam int ADDR_W     = 12;    // result-memory address width
    localparam int IMG_W      = 50;    // input image is IMG_W x IMG_W
    localparam int NUM_WIN    = (IMG_W - 2) * (IMG_W - 2);  // 2304 valid windows per frame
    localparam int TAPS       = 9;
    localparam int TAP_CENTER = 4;
    localparam int TAP_W      = 4;     // also the width of the coefficient address port

    // Largest representable output pixel, at accumulator width for signed compares.
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

endpackage

// File: rtl/conv3x3_window_mac_mac_stage.sv
// conv_mac_stage: one multiply stage followed by one accumulate stage.
// Ports: clk/rst; flush_i drops an in-flight window end; in_vld_i/pix_i/coef_i with
// first_i/last_i tap markers in; acc_o plus acc_last_vld_o (window sum complete) out.
// Latency: a pixel sampled on edge N is part of acc_o after edge N+1. No backpressure.
module conv_mac_stage
    import conv3x3_window_mac_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     in_vld_i,
    input  logic [PIX_W-1:0]         pix_i,
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic                     first_i,
    input  logic                     last_i,
    output logic signed [ACC_W-1:0]  acc_o,
    output logic                     acc_last_vld_o
);

    logic signed [ACC_W-1:0] pix_ext, coef_ext, prod_d, prod_q, acc_d, acc_q;
    logic                    p_vld_q, first_q, last_q, acc_last_q;

    // Pixel is zero-extended (always non-negative), coefficient sign-extended.
    assign pix_ext  = {{(ACC_W-PIX_W){1'b0}}, pix_i};
    assign coef_ext = {{(ACC_W-COEF_W){coef_i[COEF_W-1]}}, coef_i};
    assign prod_d   = pix_ext * coef_ext;

    // Loading on the first tap (rather than clearing) lets windows run back to back.
    assign acc_d = first_q ? prod_q : acc_q + prod_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            p_vld_q    <= 1'b0;
            acc_q      <= '0;
            acc_last_q <= 1'b0;
        end else begin
            // Stage 1 always accepts: a pixel arriving with flush_i is the new frame's tap 0.
            p_vld_q <= in_vld_i;
            if (in_vld_i) begin
                prod_q  <= prod_d;
                first_q <= first_i;
                last_q  <= last_i;
            end
            if (p_vld_q) begin
                acc_q <= acc_d;
            end
            // A window finishing across a flush belongs to the old frame: drop it.
            acc_last_q <= p_vld_q & last_q & ~flush_i;
        end
    end

    assign acc_o          = acc_q;
    assign acc_last_vld_o = acc_last_q;

endmodule

// File: rtl/conv3x3_window_mac.sv
// conv3x3_window_mac: 3x3 kernel MAC over a column-major pixel stream, shift+clamp to 8 bits.
// Ports: clk/rst, frame_start, pix_in/pix_valid, coef_wr/coef_addr/coef_data in;
// conv_out/conv_valid/out_addr/done out. Latency: 9th pixel on edge N -> conv_valid after N+2.
// No backpressure; pix_valid gaps stall the tap counter only, and pixels are ignored once done.
module conv3x3_window_mac
    import conv3x3_window_mac_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic [PIX_W-1:0]         pix_in,
    input  logic                     pix_valid,
    input  logic                     coef_wr,
    input  logic [TAP_W-1:0]         coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic [PIX_W-1:0]         conv_out,
    output logic                     conv_valid,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     done
);

    logic [TAP_W-1:0]         tap_q, tap_d, tap_cur;
    logic                     accept;
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [ACC_W-1:0]  acc, acc_sh;
    logic                     acc_last_vld;
    logic [PIX_W-1:0]         conv_d;
    logic [PIX_W-1:0]         conv_out_q;
    logic                     conv_valid_q, done_q;
    logic [ADDR_W-1:0]        out_addr_q;

    // frame_start realigns immediately, so a pixel in the same cycle is tap 0
    // and is accepted even if the previous frame had finished.
    always_comb begin
        tap_cur = frame_start ? '0 : tap_q;
        accept  = pix_valid & (~done_q | frame_start);
        tap_d   = tap_q;
        if (accept) begin
            tap_d = (tap_cur == TAP_W'(TAPS - 1)) ? '0 : tap_cur + 1'b1;
        end else if (frame_start) begin
            tap_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q <= '0;
        end else begin
            tap_q <= tap_d;
        end
    end

    // Coefficient file. A same-edge write and pixel read sees the old value
    // because the multiplier samples coef_q before this update lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= '0;
            end
            coef_q[TAP_CENTER] <= COEF_W'(1 << SHIFT);
        end else if (coef_wr && (coef_addr < TAP_W'(TAPS))) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    conv_mac_stage u_mac (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (frame_start),
        .in_vld_i       (accept),
        .pix_i          (pix_in),
        .coef_i         (coef_q[tap_cur]),
        .first_i        (tap_cur == '0),
        .last_i         (tap_cur == TAP_W'(TAPS - 1)),
        .acc_o          (acc),
        .acc_last_vld_o (acc_last_vld)
    );

    always_comb begin
        acc_sh = acc >>> SHIFT;
        if (acc_sh < 0) begin
            conv_d = '0;
        end else if (acc_sh > PIX_MAX) begin
            conv_d = '1;
        end else begin
            conv_d = acc_sh[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conv_out_q   <= '0;
            conv_valid_q <= 1'b0;
            out_addr_q   <= '0;
            done_q       <= 1'b0;
        end else if (frame_start) begin
            conv_valid_q <= 1'b0;
            out_addr_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            conv_valid_q <= acc_last_vld;
            if (acc_last_vld) begin
                conv_out_q <= conv_d;
            end
            // out_addr names the result currently on conv_out, so it moves after the strobe.
            if (conv_valid_q) begin
                out_addr_q <= out_addr_q + 1'b1;
                if (out_addr_q == ADDR_W'(NUM_WIN - 1)) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign conv_out   = conv_out_q;
    assign conv_valid = conv_valid_q;
    assign out_addr   = out_addr_q;
    assign done       = done_q;

endmodule

// File: tb/tb_conv3x3_window_mac.sv
module tb_conv3x3_window_mac;
    import conv3x3_window_mac_pkg::*;

    localparam int SHIFT = 0;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     frame_start = 1'b0;
    logic [PIX_W-1:0]         pix_in = '0;
    logic                     pix_valid = 1'b0;
    logic                     coef_wr = 1'b0;
    logic [TAP_W-1:0]         coef_addr = '0;
    logic signed [COEF_W-1:0] coef_data = '0;
    logic [PIX_W-1:0]         conv_out;
    logic                     conv_valid;
    logic [ADDR_W-1:0]        out_addr;
    logic                     done;

    conv3x3_window_mac #(.SHIFT(SHIFT)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .coef_wr    (coef_wr),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .conv_out   (conv_out),
        .conv_valid (conv_valid),
        .out_addr   (out_addr),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;

    // Expected result: value, address and the cycle in which conv_valid must be seen.
    typedef struct {
        int val;
        int addr;
        int due;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: a window is just the dot product of the kernel with the
    // nine pixels in arrival order; each product uses the kernel as it stood
    // when the pixel was presented.
    int m_coef[TAPS];
    int m_tap, m_acc, m_addr;
    bit m_done;
    int exp_override = -1;

    function automatic int ref_pix(int sum);
        int s;
        s = sum >>> SHIFT;
        if (s < 0) return 0;
        if (s > (1 << PIX_W) - 1) return (1 << PIX_W) - 1;
        return s;
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) m_coef[i] = 0;
        m_coef[TAP_CENTER] = 1 << SHIFT;
        m_tap  = 0;
        m_acc  = 0;
        m_addr = 0;
        m_done = 1'b0;
    endtask

    // Drive one cycle of inputs at the falling edge and advance the model.
    task automatic send(bit v, int pix, bit fs = 1'b0, bit wr = 1'b0, int wa = 0, int wd = 0);
        @(negedge clk);
        pix_valid   = v;
        pix_in      = PIX_W'(pix);
        frame_start = fs;
        coef_wr     = wr;
        coef_addr   = TAP_W'(wa);
        coef_data   = COEF_W'(wd);
        if (fs) begin
            m_tap  = 0;
            m_done = 1'b0;
            m_addr = 0;
        end
        if (v && !m_done) begin
            if (m_tap == 0) m_acc = pix * m_coef[0];
            else            m_acc = m_acc + pix * m_coef[m_tap];
            if (m_tap == TAPS - 1) begin
                exp_q.push_back('{(exp_override >= 0) ? exp_override : ref_pix(m_acc),
                                  m_addr, cyc + 3});
                m_addr++;
                if (m_addr == NUM_WIN) m_done = 1'b1;
            end
            m_tap = (m_tap + 1) % TAPS;
        end
        if (wr && wa < TAPS) m_coef[wa] = wd;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) send(1'b0, 0);
    endtask

    task automatic send_win(input int p[TAPS], input int gap_pct);
        for (int i = 0; i < TAPS; i++) begin
            while ($urandom_range(99) < gap_pct) send(1'b0, 0);
            send(1'b1, p[i]);
        end
    endtask

    task automatic set_kernel(input int k[TAPS]);
        for (int i = 0; i < TAPS; i++) send(1'b0, 0, 1'b0, 1'b1, i, k[i]);
    endtask

    always @(negedge clk) begin
        if (!rst && conv_valid) begin
            exp_t e;
            n_valid++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got conv_out=%0d out_addr=%0d, expected no result (cycle %0d)",
                         conv_out, out_addr, cyc);
            end else begin
                e = exp_q.pop_front();
                check("conv_out", int'(conv_out), e.val);
                check("out_addr", int'(out_addr), e.addr);
                check("latency_cycle", cyc, e.due);
            end
        end
    end

    typedef struct {
        int k[TAPS];
        int p[TAPS];
        int res;
    } vec_t;

    vec_t tbl[7];
    int   ramp[TAPS];
    int   lap[TAPS];
    int   win[TAPS];
    int   base_valid;

    initial begin
        // Entry 0 relies on the reset identity kernel; the others load their kernel first.
        tbl[0] = '{'{0,0,0,0,1,0,0,0,0},          '{10,20,30,40,50,60,70,80,90},          50};
        tbl[1] = '{'{1,1,1,1,1,1,1,1,1},          '{200,200,200,200,200,200,200,200,200}, 255};
        tbl[2] = '{'{-1,-1,-1,-1,-1,-1,-1,-1,-1}, '{200,200,200,200,200,200,200,200,200}, 0};
        tbl[3] = '{'{-1,-1,-1,-1,8,-1,-1,-1,-1},  '{100,100,100,100,100,100,100,100,100}, 0};
        tbl[4] = '{'{-1,-1,-1,-1,8,-1,-1,-1,-1},  '{100,100,100,100,120,100,100,100,100}, 160};
        tbl[5] = '{'{1,1,1,1,1,1,1,1,1},          '{1,2,3,4,5,6,7,8,9},                   45};
        tbl[6] = '{'{2,0,0,0,0,0,0,0,3},          '{7,255,255,255,255,255,255,255,80},    254};
        ramp   = '{10,20,30,40,50,60,70,80,90};
        lap    = '{-1,-1,-1,-1,8,-1,-1,-1,-1};

        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_conv_out", int'(conv_out), 0);
        check("reset_conv_valid", int'(conv_valid), 0);
        check("reset_out_addr", int'(out_addr), 0);
        check("reset_done", int'(done), 0);

        // Table vectors: fixed kernels and pixels with hand-computed results.
        for (int i = 0; i < 7; i++) begin
            if (i > 0) set_kernel(tbl[i].k);
            exp_override = tbl[i].res;
            send_win(tbl[i].p, 0);
            exp_override = -1;
            idle(4);
        end

        // Back-to-back Laplacian windows on a fresh frame: addresses 0 then 1.
        set_kernel(lap);
        send(1'b0, 0, 1'b1);
        exp_override = 160;
        send_win(tbl[4].p, 0);
        exp_override = 0;
        send_win(tbl[3].p, 0);
        exp_override = -1;
        idle(4);

        // Partial window abandoned by frame_start; the pixel with frame_start is tap 0.
        for (int i = 0; i < 5; i++) send(1'b1, $urandom_range(255));
        send(1'b1, $urandom_range(255), 1'b1);
        for (int i = 1; i < TAPS; i++) send(1'b1, $urandom_range(255));
        idle(4);

        // Random kernels, pixels, stalls and coefficient writes (some to ignored
        // addresses, some on the same edge as a pixel).
        send(1'b0, 0, 1'b1);
        base_valid = n_valid;
        for (int w = 0; w < 24; w++) begin
            for (int t = 0; t < TAPS; t++) begin
                while ($urandom_range(99) < 30) begin
                    if ($urandom_range(3) == 0)
                        send(1'b0, 0, 1'b0, 1'b1, $urandom_range(15), int'($urandom_range(255)) - 128);
                    else
                        send(1'b0, 0);
                end
                if ($urandom_range(4) == 0)
                    send(1'b1, $urandom_range(255), 1'b0, 1'b1, $urandom_range(15),
                         int'($urandom_range(255)) - 128);
                else
                    send(1'b1, $urandom_range(255));
            end
        end
        idle(4);
        check("stall_valid_count", n_valid - base_valid, 24);

        // Mid-run reset after a coefficient write restores the identity kernel.
        send(1'b0, 0, 1'b0, 1'b1, TAP_CENTER, 5);
        send_win(ramp, 0);
        idle(4);
        @(negedge clk);
        rst = 1'b1;
        pix_valid = 1'b0;
        coef_wr = 1'b0;
        frame_start = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        exp_override = 50;
        send_win(ramp, 0);
        exp_override = -1;
        idle(4);

        // Full frame with the identity kernel, then pixels after done are ignored.
        send(1'b0, 0, 1'b1);
        for (int w = 0; w < NUM_WIN; w++) begin
            for (int t = 0; t < TAPS; t++) win[t] = $urandom_range(255);
            send_win(win, 0);
        end
        idle(4);
        check("done_after_frame", int'(done), 1);
        check("out_addr_after_frame", int'(out_addr), NUM_WIN);
        for (int i = 0; i < 2 * TAPS; i++) send(1'b1, $urandom_range(255));
        idle(5);
        check("done_sticky", int'(done), 1);

        // New frame: frame_start with a pixel in the same cycle.
        send(1'b1, 77, 1'b1);
        send(1'b1, $urandom_range(255));
        check("done_cleared", int'(done), 0);
        check("out_addr_cleared", int'(out_addr), 0);
        for (int i = 2; i < TAPS; i++) send(1'b1, (i == TAP_CENTER) ? 123 : $urandom_range(255));
        idle(4);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_result: got no conv_valid, expected conv_out=%0d out_addr=%0d by cycle %0d",
                     e.val, e.addr, e.due);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
